// File: rtl/nla_mult_pkg.sv
// nla_mult_pkg: shared widths and the result record for the multiplier normalizer.
package nla_mult_pkg;
    localparam int MULT_W       = 24;
    localparam int MULT_LATENCY = 10;
    localparam int SHIFT        = 12;
    localparam int OUT_W        = 24;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sat;
    } mult_result_t;
endpackage

// File: rtl/mult_result_fifo.sv
// mult_result_fifo: DEPTH-entry FIFO of result records; push and pop may coincide at any occupancy.
module mult_result_fifo
    import nla_mult_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = mult_result_t
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    T mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = count == DEPTH_C;
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/mult_result_normalizer.sv
// mult_result_normalizer: aligns multiplier products with their issues, rounds half-up,
// saturates to OUT_W bits and buffers results behind a credit-limited ready/valid port.
module mult_result_normalizer #(
    parameter int MULT_W       = nla_mult_pkg::MULT_W,
    parameter int MULT_LATENCY = nla_mult_pkg::MULT_LATENCY,
    parameter int SHIFT        = nla_mult_pkg::SHIFT,
    parameter int OUT_W        = nla_mult_pkg::OUT_W,
    parameter int DEPTH        = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [2*MULT_W-1:0] product_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [OUT_W-1:0]    result_o,
    output logic                sat_o,
    output logic [15:0]         sat_count_o
);
    localparam int SUM_W = 2*MULT_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sat;
    } res_t;

    logic [MULT_LATENCY-1:0] vld_sr;
    logic [CNT_W-1:0]        reserved;
    logic [SUM_W-1:0]        r1_sum, q;
    logic                    r1_v, r2_v, fire, pop, q_sat;
    logic                    fifo_full, fifo_empty, push;
    res_t                    r2, head;

    assign issue_ready_o  = reserved < CNT_W'(DEPTH);
    assign fire           = issue_valid_i && issue_ready_o;
    assign result_valid_o = !fifo_empty;
    assign pop            = result_valid_o && result_ready_i;
    assign q              = r1_sum >> SHIFT;
    assign q_sat          = q > SUM_W'({OUT_W{1'b1}});
    // Credits reserve a slot per fire, so this guard never drops a result.
    assign push           = r2_v && (!fifo_full || pop);
    assign result_o       = head.data;
    assign sat_o          = head.sat;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_sr      <= '0;
            reserved    <= '0;
            r1_v        <= 1'b0;
            r1_sum      <= '0;
            r2_v        <= 1'b0;
            r2          <= '0;
            sat_count_o <= '0;
        end else begin
            vld_sr   <= {vld_sr[MULT_LATENCY-2:0], fire};
            reserved <= reserved + CNT_W'(fire) - CNT_W'(pop);
            r1_v     <= vld_sr[MULT_LATENCY-1];
            r1_sum   <= {1'b0, product_i} + (SUM_W'(1) << (SHIFT-1));
            r2_v     <= r1_v;
            r2.sat   <= q_sat;
            r2.data  <= q_sat ? '1 : q[OUT_W-1:0];
            if (pop && head.sat && sat_count_o != '1) sat_count_o <= sat_count_o + 1'b1;
        end
    end

    mult_result_fifo #(.DEPTH(DEPTH), .T(res_t)) u_fifo (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .push  (push),
        .wdata (r2),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_mult_result_normalizer.sv
// tb_mult_result_normalizer: directed stimulus with a scoreboard queue and a decoupled output monitor.
module tb_mult_result_normalizer;
    localparam int L = 10;

    logic        clk = 1'b0, rstn = 1'b0, issue_valid = 1'b0, result_ready = 1'b0;
    logic        issue_ready, result_valid, sat;
    logic [47:0] product, next_prod = '0;
    logic [23:0] result;
    logic [15:0] sat_count;
    logic [47:0] pipe [L];
    logic [24:0] exp_q [$];
    logic [24:0] e;
    int          n_chk = 0, n_pass = 0, cyc = 0, fires = 0, t_fire = 0;

    mult_result_normalizer dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .product_i     (product),
        .result_valid_o(result_valid),
        .result_ready_i(result_ready),
        .result_o      (result),
        .sat_o         (sat),
        .sat_count_o   (sat_count)
    );

    always #5 clk = ~clk;

    // Multiplier model: the operand issued in cycle t shows up on product in cycle t+L.
    always @(posedge clk) begin
        pipe[0] <= issue_valid ? next_prod : 48'hA5A5_5A5A_0F0F;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign product = pipe[L-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rstn && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_result: got %0h sat %0b expected none", result, sat);
            end else begin
                e = exp_q.pop_front();
                chk("result_data", 64'(result), 64'(e[24:1]));
                chk("result_sat", 64'(sat), 64'(e[0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [47:0] p, input logic [23:0] d, input logic s);
        issue_valid = 1'b1;
        next_prod   = p;
        @(negedge clk);
        if (issue_ready) begin
            exp_q.push_back({d, s});
            fires++;
            t_fire = cyc;
        end
        step();
        issue_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, run, best, stale;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_sat", 64'(sat), 64'd0);
        chk("rst_sat_count", 64'(sat_count), 64'd0);
        step();
        rstn = 1'b1;
        step();

        result_ready = 1'b1;
        drive(48'h0000_0100_0000, 24'h001000, 1'b0);
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (result_valid) begin
                lat = cyc - t_fire;
                break;
            end
        end
        chk("latency", 64'(lat), 64'd13);
        step();
        drain();

        drive(48'h800, 24'h000001, 1'b0);
        drive(48'h7FF, 24'h000000, 1'b0);
        drive(48'h000F_FFFF_F7FF, 24'hFFFFFF, 1'b0);
        drain();

        chk("sat_count_0", 64'(sat_count), 64'd0);
        drive(48'hFFFF_FFFF_FFFF, 24'hFFFFFF, 1'b1);
        drain();
        chk("sat_count_1", 64'(sat_count), 64'd1);
        drive(48'h000F_FFFF_F800, 24'hFFFFFF, 1'b1);
        drain();
        chk("sat_count_2", 64'(sat_count), 64'd2);

        result_ready = 1'b0;
        fires = 0;
        for (int k = 1; k <= 6; k++) drive(48'(k) << 12, 24'(k), 1'b0);
        chk("bp_fires", 64'(fires), 64'd4);
        chk("bp_ready_low", 64'(issue_ready), 64'd0);
        repeat (16) step();
        chk("bp_head_valid", 64'(result_valid), 64'd1);
        chk("bp_head_stable", 64'(result), 64'd1);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("pop_frees_credit", 64'(issue_ready), 64'd1);
        result_ready = 1'b1;
        drive(48'd5 << 12, 24'd5, 1'b0);
        result_ready = 1'b0;
        chk("fire_pop_same_cycle", 64'(issue_ready), 64'd1);
        drive(48'd6 << 12, 24'd6, 1'b0);
        chk("refill_ready_low", 64'(issue_ready), 64'd0);
        repeat (16) step();
        chk("full_head", 64'(result), 64'd3);
        result_ready = 1'b1;
        drain();
        chk("bp_ready_back", 64'(issue_ready), 64'd1);

        for (int k = 7; k <= 10; k++) drive(48'(k) << 12, 24'(k), 1'b0);
        run = 0;
        best = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            run = result_valid ? run + 1 : 0;
            if (run > best) best = run;
        end
        chk("throughput_run", 64'(best), 64'd4);
        step();
        drain();

        result_ready = 1'b0;
        for (int k = 11; k <= 13; k++) drive(48'(k) << 12, 24'(k), 1'b0);
        repeat (11) step();
        chk("pre_reset_valid", 64'(result_valid), 64'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(result_valid), 64'd0);
        chk("mid_rst_ready", 64'(issue_ready), 64'd1);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_sat", 64'(sat), 64'd0);
        chk("mid_rst_sat_count", 64'(sat_count), 64'd0);
        exp_q.delete();
        step();
        rstn = 1'b1;
        result_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (result_valid) stale++;
        end
        chk("no_stale_results", 64'(stale), 64'd0);
        step();
        drive(48'd14 << 12, 24'd14, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
